// File: rtl/wbs_uart_peripheral.sv
// Wishbone classic slave exposing an 8N1 UART as four registers:
// TX FIFO (0x0), status (0x4), divisor (0x8) and control (0xC).
module wbs_uart_peripheral #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int BAUD_RATE     = 9600,
  parameter int CLOCK_FREQ    = 50000000,
  parameter int TX_FIFO_DEPTH = 4
) (
`ifdef USE_POWER_PINS
  inout  wire                   vccd1,
  inout  wire                   vssd1,
`endif
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  input  logic                  uart_rx,
  output logic                  uart_tx
);

  localparam int          PW        = $clog2(TX_FIFO_DEPTH);
  localparam logic [15:0] DIV_RESET = 16'(CLOCK_FREQ / BAUD_RATE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } ser_state_e;

  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [15:0]           divisor_q, divisor_d;
  logic                  rx_en_q, rx_en_d, tx_en_q, tx_en_d;
  logic                  tx_drop_q, tx_drop_d;

  logic [7:0]            mem_q [TX_FIFO_DEPTH];
  logic [7:0]            mem_d [TX_FIFO_DEPTH];
  logic [PW:0]           wptr_q, wptr_d, rptr_q, rptr_d;

  ser_state_e            tx_state_q, tx_state_d;
  logic [15:0]           tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]            tx_bit_q, tx_bit_d;
  logic [7:0]            tx_shift_q, tx_shift_d;
  logic                  tx_q, tx_d;

  logic                  rx_sync1_q, rx_sync2_q, rx_prev_q;
  ser_state_e            rx_state_q, rx_state_d;
  logic [15:0]           rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]            rx_bit_q, rx_bit_d;
  logic [7:0]            rx_shift_q, rx_shift_d;
  logic [7:0]            rx_byte_q, rx_byte_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_overrun_q, rx_overrun_d;
  logic                  frame_err_q, frame_err_d;

  logic                  req_s, data_wr_s, data_rd_s, stat_wr_s, div_wr_s, ctrl_wr_s;
  logic [1:0]            sel_s;
  logic                  tx_full_s, tx_empty_s, tx_busy_s, pop_s, push_ok_s;
  logic [6:0]            status_s;
  logic                  unused_s;

  assign unused_s = ^{wb_adr_i[ADDR_WIDTH-1:4], wb_adr_i[1:0], wb_dat_i[DATA_WIDTH-1:16]};

  // Bus request decode; a request is ignored while its ack is being returned
  always_comb begin
    req_s     = wb_cyc_i & wb_stb_i & ~ack_q;
    sel_s     = wb_adr_i[3:2];
    data_wr_s = req_s &  wb_we_i & (sel_s == 2'd0);
    data_rd_s = req_s & ~wb_we_i & (sel_s == 2'd0);
    stat_wr_s = req_s &  wb_we_i & (sel_s == 2'd1);
    div_wr_s  = req_s &  wb_we_i & (sel_s == 2'd2);
    ctrl_wr_s = req_s &  wb_we_i & (sel_s == 2'd3);
  end

  // TX FIFO: the extra pointer bit separates full from empty
  always_comb begin
    tx_empty_s = (wptr_q == rptr_q);
    tx_full_s  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    pop_s      = (tx_state_q == S_IDLE) & tx_en_q & ~tx_empty_s;
    push_ok_s  = data_wr_s & (~tx_full_s | pop_s);
    mem_d      = mem_q;
    wptr_d     = push_ok_s ? (wptr_q + {{PW{1'b0}}, 1'b1}) : wptr_q;
    rptr_d     = pop_s ? (rptr_q + {{PW{1'b0}}, 1'b1}) : rptr_q;
    if (push_ok_s) begin
      mem_d[wptr_q[PW-1:0]] = wb_dat_i[7:0];
    end else begin
      mem_d = mem_q;
    end
  end

  // Register file writes and the registered read data path
  always_comb begin
    tx_busy_s = (tx_state_q != S_IDLE);
    status_s  = {tx_drop_q, frame_err_q, tx_busy_s, rx_overrun_q, rx_valid_q, tx_empty_s, tx_full_s};
    ack_d     = req_s;
    dat_d     = '0;
    if (req_s && !wb_we_i) begin
      case (sel_s)
        2'd0:    dat_d = rx_valid_q ? DATA_WIDTH'(rx_byte_q) : '0;
        2'd1:    dat_d = DATA_WIDTH'(status_s);
        2'd2:    dat_d = DATA_WIDTH'(divisor_q);
        2'd3:    dat_d = DATA_WIDTH'({tx_en_q, rx_en_q});
        default: dat_d = '0;
      endcase
    end else begin
      dat_d = '0;
    end
    if (div_wr_s) begin
      divisor_d = (wb_dat_i[15:0] < 16'd4) ? 16'd4 : wb_dat_i[15:0];
    end else begin
      divisor_d = divisor_q;
    end
    rx_en_d   = ctrl_wr_s ? wb_dat_i[0] : rx_en_q;
    tx_en_d   = ctrl_wr_s ? wb_dat_i[1] : tx_en_q;
    tx_drop_d = tx_drop_q & ~(stat_wr_s & wb_dat_i[6]);
    if (data_wr_s && tx_full_s && !pop_s) begin
      tx_drop_d = 1'b1;
    end else begin
      tx_drop_d = tx_drop_d;
    end
  end

  // TX serialiser; divisor is latched at each start bit
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop_s) begin
          tx_state_d = S_START;
          tx_cnt_d   = 16'd0;
          tx_div_d   = divisor_q;
          tx_shift_d = mem_q[rptr_q[PW-1:0]];
          tx_d       = 1'b0;
        end else begin
          tx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = 16'd0;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_cnt_d = 16'd0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == tx_div_q - 16'd1) begin
          tx_state_d = S_IDLE;
          tx_cnt_d   = 16'd0;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  // RX deserialiser; a DATA read on the completing edge frees the holding register
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_div_d     = rx_div_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_byte_d    = rx_byte_q;
    rx_valid_d   = rx_valid_q & ~data_rd_s;
    rx_overrun_d = rx_overrun_q & ~(stat_wr_s & wb_dat_i[3]);
    frame_err_d  = frame_err_q & ~(stat_wr_s & wb_dat_i[5]);
    case (rx_state_q)
      S_IDLE: begin
        if (rx_en_q && rx_prev_q && !rx_sync2_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = 16'd0;
          rx_div_d   = divisor_q;
        end else begin
          rx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (!rx_en_q) begin
          rx_state_d = S_IDLE;
        end else if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
          rx_cnt_d   = 16'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (!rx_en_q) begin
          rx_state_d = S_IDLE;
        end else if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_d   = 16'd0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          rx_state_d = (rx_bit_q == 3'd7) ? S_STOP : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (!rx_en_q) begin
          rx_state_d = S_IDLE;
        end else if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_state_d = S_IDLE;
          rx_cnt_d   = 16'd0;
          if (!rx_sync2_q) begin
            frame_err_d = 1'b1;
          end else if (!rx_valid_d) begin
            rx_byte_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_overrun_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q        <= 1'b0;
      dat_q        <= '0;
      divisor_q    <= DIV_RESET;
      rx_en_q      <= 1'b0;
      tx_en_q      <= 1'b1;
      tx_drop_q    <= 1'b0;
      mem_q        <= '{default: 8'h00};
      wptr_q       <= '0;
      rptr_q       <= '0;
      tx_state_q   <= S_IDLE;
      tx_cnt_q     <= 16'd0;
      tx_div_q     <= DIV_RESET;
      tx_bit_q     <= 3'd0;
      tx_shift_q   <= 8'h00;
      tx_q         <= 1'b1;
      rx_sync1_q   <= 1'b1;
      rx_sync2_q   <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= S_IDLE;
      rx_cnt_q     <= 16'd0;
      rx_div_q     <= DIV_RESET;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'h00;
      rx_byte_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      ack_q        <= ack_d;
      dat_q        <= dat_d;
      divisor_q    <= divisor_d;
      rx_en_q      <= rx_en_d;
      tx_en_q      <= tx_en_d;
      tx_drop_q    <= tx_drop_d;
      mem_q        <= mem_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_div_q     <= tx_div_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_q         <= tx_d;
      rx_sync1_q   <= uart_rx;
      rx_sync2_q   <= rx_sync1_q;
      rx_prev_q    <= rx_sync2_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_div_q     <= rx_div_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign uart_tx  = tx_q;

endmodule

// File: tb/tb_wbs_uart_peripheral.sv
// Directed bench for wbs_uart_peripheral with TX/RX byte scoreboards.
module tb_wbs_uart_peripheral;

  localparam logic [31:0] A_DATA = 32'h0;
  localparam logic [31:0] A_STAT = 32'h4;
  localparam logic [31:0] A_DIV  = 32'h8;
  localparam logic [31:0] A_CTRL = 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic [31:0] rdat;
  logic        ack;
  logic        uart_rx = 1'b1;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];

  always #5 clk = ~clk;

  wbs_uart_peripheral #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .BAUD_RATE(9600),
    .CLOCK_FREQ(50000000), .TX_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat), .wb_ack_o(ack),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] r);
    int lat;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (ack !== 1'b1 && lat < 4);
    chk("wb_ack_latency", lat, 1);
    r = rdat;
    if (w) chk("wb_dat_o_on_write", rdat, 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(1'b1, a, d, r);
  endtask

  task automatic wb_read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(1'b0, a, 32'h0, r);
    chk(tag, r, exp);
  endtask

  task automatic rx_read_chk(input string tag);
    logic [7:0] e;
    e = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'hxx;
    wb_read_chk(tag, A_DATA, {24'h0, e});
  endtask

  // Captures one frame at divisor 8; every sample of each bit must agree
  task automatic tx_frame_chk(input string tag, output int wait_cyc);
    logic [79:0] s;
    logic [7:0]  b, e;
    logic        ok;
    logic        want;
    wait_cyc = 0;
    do begin
      @(negedge clk);
      wait_cyc++;
    end while (uart_tx !== 1'b0 && wait_cyc < 3000);
    if (uart_tx !== 1'b0) begin
      chk({tag, "_start_timeout"}, {31'h0, uart_tx}, 32'h0);
    end else begin
      s[0] = 1'b0;
      for (int i = 1; i < 80; i++) begin
        @(negedge clk);
        s[i] = uart_tx;
      end
      for (int k = 0; k < 8; k++) b[k] = s[8 * (k + 1) + 4];
      ok = 1'b1;
      for (int i = 0; i < 80; i++) begin
        if (i < 8)       want = 1'b0;
        else if (i >= 72) want = 1'b1;
        else             want = b[i / 8 - 1];
        if (s[i] !== want) ok = 1'b0;
      end
      chk({tag, "_shape"}, {31'h0, ok}, 32'h1);
      e = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'hxx;
      chk({tag, "_byte"}, {24'h0, b}, {24'h0, e});
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (8) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  task automatic tx_quiet_chk(input string tag, input int n);
    int lows;
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    chk(tag, lows, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int         w;
    logic [3:0] pat;

    // Reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
    chk("reset_ack", {31'h0, ack}, 32'h0);
    chk("reset_dat_o", rdat, 32'h0);
    rst = 1'b0;
    wb_read_chk("reset_status", A_STAT, 32'h2);
    wb_read_chk("reset_divisor", A_DIV, 32'd5208);
    wb_read_chk("reset_ctrl", A_CTRL, 32'h2);
    chk("idle_uart_tx", {31'h0, uart_tx}, 32'h1);

    // Held strobe is acked every other cycle
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STAT;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat[i] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("b2b_ack_pattern", {28'h0, pat}, 32'h5);

    // Divisor clamp and single frame
    wb_write(A_DIV, 32'd2);
    wb_read_chk("divisor_clamp", A_DIV, 32'd4);
    wb_write(A_DIV, 32'd8);
    wb_read_chk("divisor_8", A_DIV, 32'd8);
    wb_write(A_DATA, 32'hA5);
    tx_exp_q.push_back(8'hA5);
    fork
      begin
        tx_frame_chk("tx_a5", w);
        chk("tx_start_latency", w, 2);
      end
      begin
        repeat (30) @(negedge clk);
        wb_read_chk("status_busy_1", A_STAT, 32'h12);
        repeat (30) @(negedge clk);
        wb_read_chk("status_busy_2", A_STAT, 32'h12);
      end
    join
    repeat (5) @(negedge clk);
    wb_read_chk("status_after_frame", A_STAT, 32'h2);

    // FIFO fill with tx disabled, fifth byte dropped
    wb_write(A_CTRL, 32'h0);
    for (int v = 8'h11; v <= 8'h15; v++) begin
      wb_write(A_DATA, 32'(v));
      if (tx_exp_q.size() < 4) tx_exp_q.push_back(8'(v));
    end
    wb_read_chk("status_full_drop", A_STAT, 32'h41);
    wb_write(A_CTRL, 32'h2);
    for (int i = 0; i < 4; i++) tx_frame_chk("tx_fifo", w);
    tx_quiet_chk("tx_no_dropped_byte", 200);
    wb_read_chk("status_drop_sticky", A_STAT, 32'h42);
    wb_write(A_STAT, 32'h40);
    wb_read_chk("status_drop_cleared", A_STAT, 32'h2);

    // RX single byte
    wb_write(A_CTRL, 32'h3);
    send_rx(8'h3C, 1'b1);
    rx_exp_q.push_back(8'h3C);
    repeat (4) @(negedge clk);
    wb_read_chk("status_rx_valid", A_STAT, 32'h6);
    rx_read_chk("rx_3c");
    wb_read_chk("status_rx_consumed", A_STAT, 32'h2);
    wb_read_chk("rx_empty_read", A_DATA, 32'h0);

    // Overrun keeps the older byte
    send_rx(8'h01, 1'b1);
    rx_exp_q.push_back(8'h01);
    send_rx(8'h02, 1'b1);
    repeat (4) @(negedge clk);
    wb_read_chk("status_overrun", A_STAT, 32'hE);
    rx_read_chk("rx_overrun_old");
    wb_read_chk("status_overrun_sticky", A_STAT, 32'hA);
    wb_write(A_STAT, 32'h8);
    wb_read_chk("status_overrun_cleared", A_STAT, 32'h2);

    // Framing error, then a short glitch
    send_rx(8'h55, 1'b0);
    repeat (4) @(negedge clk);
    wb_read_chk("status_frame_err", A_STAT, 32'h22);
    wb_write(A_STAT, 32'h20);
    wb_read_chk("status_frame_cleared", A_STAT, 32'h2);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (100) @(negedge clk);
    wb_read_chk("status_after_glitch", A_STAT, 32'h2);
    send_rx(8'h96, 1'b1);
    rx_exp_q.push_back(8'h96);
    repeat (4) @(negedge clk);
    rx_read_chk("rx_after_glitch");

    // Reset mid-frame aborts the transmission
    wb_write(A_DATA, 32'h5A);
    repeat (4) @(negedge clk);
    chk("tx_mid_frame_low", {31'h0, uart_tx}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("tx_after_reset", {31'h0, uart_tx}, 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wb_read_chk("status_after_reset", A_STAT, 32'h2);
    wb_read_chk("divisor_after_reset", A_DIV, 32'd5208);
    wb_read_chk("ctrl_after_reset", A_CTRL, 32'h2);
    tx_quiet_chk("tx_quiet_after_reset", 200);
    chk("tx_scoreboard_drained", tx_exp_q.size(), 0);
    chk("rx_scoreboard_drained", rx_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
